// File: rtl/fma_result_packer.sv
// Packs compacted per-lane FMA results into fixed-width lines and queues them for write-back.
// Latency: a line completed at edge k is visible on line_out/line_valid right after edge k if the queue was empty.
// Backpressure: line_ready_in pops the head line. A line completed while the queue is full and not popping is dropped, and overflow_out latches.
module fma_result_packer #(
  parameter int FMA_COUNT  = 2,
  parameter int WORD_WIDTH = 16,
  parameter int LINE_WIDTH = 96,
  parameter int DEPTH      = 4,
  localparam int WPL = LINE_WIDTH / WORD_WIDTH,
  localparam int SW  = $clog2(WPL + 1),
  localparam int CW  = $clog2(DEPTH + 1)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [WORD_WIDTH*FMA_COUNT-1:0] fma_out,
  input  logic [FMA_COUNT-1:0]            fma_valid_out,
  input  logic                            flush_in,
  output logic [LINE_WIDTH-1:0]           line_out,
  output logic                            line_valid,
  input  logic                            line_ready_in,
  output logic                            overflow_out,
  output logic [CW-1:0]                   line_count_out,
  output logic [SW-1:0]                   staged_words_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CAT = WPL + FMA_COUNT;

  // Staging register: word 0 is the oldest word and lands at the line MSB.
  logic [WORD_WIDTH-1:0] stage_q [WPL];
  logic [WORD_WIDTH-1:0] stage_d [WPL];
  logic [SW-1:0]         staged_q, staged_d;
  logic                  pend_q, pend_d;

  logic [LINE_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  ovf_q;

  logic [WORD_WIDTH-1:0] cat [CAT];
  logic [LINE_WIDTH-1:0] line_d;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  push_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Append this cycle's valid lanes (highest lane first) behind the staged words and decide whether a line leaves.
  always_comb begin
    int staged;
    int pos;
    int total;
    int lane_pos [FMA_COUNT];
    logic eff_flush;

    staged = int'(staged_q);
    pos    = staged;
    for (int i = FMA_COUNT - 1; i >= 0; i--) begin
      lane_pos[i] = pos;
      if (fma_valid_out[i]) pos = pos + 1;
    end
    total = pos;

    for (int j = 0; j < CAT; j++) begin
      cat[j] = '0;
      if (j < WPL && j < staged) cat[j] = stage_q[j];
      for (int i = 0; i < FMA_COUNT; i++) begin
        if (fma_valid_out[i] && lane_pos[i] == j) cat[j] = fma_out[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end

    line_d = '0;
    for (int j = 0; j < WPL; j++) begin
      line_d[LINE_WIDTH-1-j*WORD_WIDTH -: WORD_WIDTH] = cat[j];
    end

    // A pending flush behaves exactly like a fresh flush pulse.
    eff_flush = flush_in || pend_q;
    push      = 1'b0;
    pend_d    = 1'b0;
    staged_d  = staged_q;
    for (int j = 0; j < WPL; j++) stage_d[j] = stage_q[j];

    if (total >= WPL) begin
      // Full line leaves; the overflow words restart the staging register at the MSB.
      push = 1'b1;
      for (int j = 0; j < WPL; j++) stage_d[j] = '0;
      for (int j = 0; j < FMA_COUNT; j++) stage_d[j] = cat[WPL + j];
      staged_d = SW'(total - WPL);
      pend_d   = eff_flush && (total > WPL);
    end else if (eff_flush) begin
      // Partial line leaves zero-padded; an empty flush emits nothing.
      push = (total > 0);
      for (int j = 0; j < WPL; j++) stage_d[j] = '0;
      staged_d = '0;
    end else begin
      for (int j = 0; j < WPL; j++) stage_d[j] = cat[j];
      staged_d = SW'(total);
    end
  end

  assign line_valid       = (count_q != '0);
  assign line_out         = line_valid ? mem_q[rd_ptr_q] : '0;
  assign pop              = line_valid && line_ready_in;
  assign full             = (count_q == CW'(DEPTH));
  assign push_acc         = push && (!full || pop);
  assign overflow_out     = ovf_q;
  assign line_count_out   = count_q;
  assign staged_words_out = staged_q;

  // Staging register and pending-flush state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int j = 0; j < WPL; j++) stage_q[j] <= '0;
      staged_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      for (int j = 0; j < WPL; j++) stage_q[j] <= stage_d[j];
      staged_q <= staged_d;
      pend_q   <= pend_d;
    end
  end

  // Output line queue with modulo-DEPTH pointers and sticky drop flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_acc) begin
        mem_q[wr_ptr_q] <= line_d;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_acc) - CW'(pop);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

endmodule
